// File: rtl/game_state_eval.sv
// Sequential tic-tac-toe board evaluator feeding reward_gen.
// Latches a board on start, scans the eight winning lines one per cycle, then resolves a registered game_state.
module game_state_eval #(
    parameter logic [1:0] AGENT_MARK = 2'b01,
    parameter logic [1:0] OPP_MARK   = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [17:0] board,
    output logic [1:0]  game_state,
    output logic        valid,
    output logic        busy,
    output logic        err,
    output logic [2:0]  win_line
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SCAN    = 2'b01,
        RESOLVE = 2'b10
    } state_t;

    state_t state, state_nxt;

    logic [17:0]      board_q;
    logic [2:0]       cnt;
    logic             agent_hit;
    logic             opp_hit;
    logic [2:0]       pend_line;

    logic [8:0][1:0]  cells;
    logic [8:0]       illegal_cell;
    logic [8:0]       empty_cell;
    logic [3:0]       idx_a, idx_b, idx_c;
    logic             line_agent, line_opp;
    logic [1:0]       res_state;
    logic             res_err;
    logic [2:0]       res_line;

    assign cells = board_q;
    assign busy  = (state != IDLE);

    for (genvar g = 0; g < 9; g++) begin : g_cell
        assign illegal_cell[g] = (cells[g] == 2'b11);
        assign empty_cell[g]   = (cells[g] == 2'b00);
    end

    always_comb begin
        idx_a = 4'd0;
        idx_b = 4'd1;
        idx_c = 4'd2;
        case (cnt)
            3'd0: begin idx_a = 4'd0; idx_b = 4'd1; idx_c = 4'd2; end
            3'd1: begin idx_a = 4'd3; idx_b = 4'd4; idx_c = 4'd5; end
            3'd2: begin idx_a = 4'd6; idx_b = 4'd7; idx_c = 4'd8; end
            3'd3: begin idx_a = 4'd0; idx_b = 4'd3; idx_c = 4'd6; end
            3'd4: begin idx_a = 4'd1; idx_b = 4'd4; idx_c = 4'd7; end
            3'd5: begin idx_a = 4'd2; idx_b = 4'd5; idx_c = 4'd8; end
            3'd6: begin idx_a = 4'd0; idx_b = 4'd4; idx_c = 4'd8; end
            default: begin idx_a = 4'd2; idx_b = 4'd4; idx_c = 4'd6; end
        endcase
    end

    assign line_agent = (cells[idx_a] == AGENT_MARK) && (cells[idx_b] == AGENT_MARK)
                     && (cells[idx_c] == AGENT_MARK);
    assign line_opp   = (cells[idx_a] == OPP_MARK) && (cells[idx_b] == OPP_MARK)
                     && (cells[idx_c] == OPP_MARK);

    // Error outranks every win; win_line is forced to 0 on error.
    always_comb begin
        res_state = 2'b00;
        res_err   = 1'b0;
        res_line  = 3'd0;
        if ((|illegal_cell) || (agent_hit && opp_hit)) begin
            res_err = 1'b1;
        end else if (agent_hit) begin
            res_state = 2'b10;
            res_line  = pend_line;
        end else if (opp_hit) begin
            res_state = 2'b11;
            res_line  = pend_line;
        end else if (!(|empty_cell)) begin
            res_state = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (cnt == 3'd7) state_nxt = RESOLVE;
            RESOLVE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            board_q    <= '0;
            cnt        <= '0;
            agent_hit  <= 1'b0;
            opp_hit    <= 1'b0;
            pend_line  <= '0;
            game_state <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            win_line   <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        board_q   <= board;
                        agent_hit <= 1'b0;
                        opp_hit   <= 1'b0;
                        pend_line <= '0;
                        cnt       <= '0;
                    end
                end
                SCAN: begin
                    if (line_agent) agent_hit <= 1'b1;
                    if (line_opp)   opp_hit   <= 1'b1;
                    if ((line_agent || line_opp) && !agent_hit && !opp_hit)
                        pend_line <= cnt;
                    if (cnt != 3'd7) cnt <= cnt + 3'd1;
                end
                RESOLVE: begin
                    game_state <= res_state;
                    err        <= res_err;
                    win_line   <= res_line;
                    valid      <= 1'b1;
                    cnt        <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_eval.sv
// Directed self-checking bench for game_state_eval with hand-computed expectations.
module tb_game_state_eval;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [17:0] board;
    logic [1:0]  game_state;
    logic        valid;
    logic        busy;
    logic        err;
    logic [2:0]  win_line;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;
    localparam logic [1:0] E = 2'b00;
    localparam logic [1:0] B = 2'b11;

    game_state_eval #(.AGENT_MARK(2'b01), .OPP_MARK(2'b10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .board(board),
        .game_state(game_state), .valid(valid), .busy(busy),
        .err(err), .win_line(win_line)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] bd(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
        return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    // Pulses start with board b; optionally scrambles board right after the latch edge.
    // Returns the number of cycles from the start sample until valid (20 if it never came).
    task automatic run_eval(input logic [17:0] b, input bit scramble, output int lat);
        board = b;
        start = 1'b1;
        step();
        start = 1'b0;
        if (scramble) board = '1;
        lat = 0;
        while (!valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic expect_result(input string tag, input int lat, input logic [1:0] gs,
                                 input logic e, input logic [2:0] wl);
        check({tag, "_latency"}, lat, 9);
        check({tag, "_state"}, game_state, gs);
        check({tag, "_err"}, err, e);
        check({tag, "_line"}, win_line, wl);
    endtask

    task automatic count_valid(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (valid) pulses++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int vt[$];

        rst_n = 1'b0;
        start = 1'b0;
        board = '0;
        step();
        step();
        check("rst_state", game_state, 2'b00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_line", win_line, 3'd0);
        rst_n = 1'b1;
        count_valid(20, pulses);
        check("idle_no_valid", pulses, 0);

        // agent row 0
        run_eval(bd(X, X, X, E, O, O, E, E, E), 1'b0, lat);
        expect_result("agent_row", lat, 2'b10, 1'b0, 3'd0);
        check("agent_row_busy_low", busy, 1'b0);
        step();
        check("valid_falls", valid, 1'b0);
        check("state_holds", game_state, 2'b10);

        // opponent anti-diagonal, board changed during scan
        run_eval(bd(X, X, O, E, O, E, O, E, E), 1'b1, lat);
        expect_result("opp_anti", lat, 2'b11, 1'b0, 3'd7);

        run_eval(bd(X, O, X, X, O, O, O, X, X), 1'b0, lat);
        expect_result("draw", lat, 2'b01, 1'b0, 3'd0);

        run_eval(bd(X, O, X, X, O, O, O, X, E), 1'b0, lat);
        expect_result("continue", lat, 2'b00, 1'b0, 3'd0);

        run_eval(bd(E, E, E, B, E, E, E, E, E), 1'b0, lat);
        expect_result("illegal_cell", lat, 2'b00, 1'b1, 3'd0);

        run_eval(bd(X, X, X, E, E, E, O, O, O), 1'b0, lat);
        expect_result("double_win", lat, 2'b00, 1'b1, 3'd0);

        // double winner whose first hit is line 4: win_line must still be 0
        run_eval(bd(E, X, O, E, X, O, E, X, O), 1'b0, lat);
        expect_result("double_win_cols", lat, 2'b00, 1'b1, 3'd0);

        // agent wins lines 1 and 4: first hit is reported
        run_eval(bd(E, X, E, X, X, X, E, X, E), 1'b0, lat);
        expect_result("first_hit", lat, 2'b10, 1'b0, 3'd1);

        // start held high: column 0 win, valid every 10 cycles
        board = bd(X, O, E, X, O, E, X, E, E);
        start = 1'b1;
        step();
        check("held_busy", busy, 1'b1);
        for (int i = 1; i <= 25; i++) begin
            step();
            if (valid) vt.push_back(i);
        end
        start = 1'b0;
        check("held_pulses", vt.size(), 2);
        if (vt.size() >= 2) begin
            check("held_first", vt[0], 9);
            check("held_second", vt[1], 19);
        end
        check("held_state", game_state, 2'b10);
        check("held_line", win_line, 3'd3);
        lat = 0;
        while (busy && lat < 20) begin
            step();
            lat++;
        end
        check("held_drain", busy, 1'b0);
        step();

        // start pulsed during scan is ignored
        board = bd(O, O, O, X, X, E, E, E, E);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        board = bd(X, X, X, E, E, E, E, E, E);
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 3;
        while (!valid && lat < 20) begin
            step();
            lat++;
        end
        expect_result("scan_start", lat, 2'b11, 1'b0, 3'd0);
        count_valid(15, pulses);
        check("scan_start_not_queued", pulses, 0);

        // agent result first so reset has something to clear
        run_eval(bd(X, X, X, E, O, O, E, E, E), 1'b0, lat);
        check("pre_reset_state", game_state, 2'b10);
        board = bd(E, E, O, E, E, O, E, E, O);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_state", game_state, 2'b00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", valid, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_line", win_line, 3'd0);
        count_valid(15, pulses);
        check("midrst_no_valid", pulses, 0);
        run_eval(bd(E, E, O, E, E, O, E, E, O), 1'b0, lat);
        expect_result("post_reset", lat, 2'b11, 1'b0, 3'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/game_state_eval.md
# game_state_eval

Sequential board evaluator that sits directly upstream of `reward_gen`. On a `start` request it latches the 18-bit board and scans the eight winning lines, one per cycle. It then resolves the 2-bit `game_state` code (10 agent won, 11 agent lost, 01 draw, 00 continue) that `reward_gen` converts to a reward. Results are registered and qualified by a one-cycle `valid` pulse.

## Interface
- `AGENT_MARK`, default 2'b01: cell code owned by the agent.
- `OPP_MARK`, default 2'b10: cell code owned by the opponent.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: evaluation request; sampled only in IDLE.
- `board` input 18: cell i is `board[2i+1:2i]`, cells 0..8 row-major. 00 is empty; 11 is illegal.
- `game_state` output 2: registered result; holds until the next result.
- `valid` output 1: one-cycle pulse when a new `game_state` is written.
- `busy` output 1: high while an evaluation is in flight.
- `err` output 1: registered with `game_state`; high if the board was illegal.
- `win_line` output 3: index of the first winning line found (0..7); 0 if none.

## Operation
- Line order: 0 (0,1,2), 1 (3,4,5), 2 (6,7,8), 3 (0,3,6), 4 (1,4,7), 5 (2,5,8), 6 (0,4,8), 7 (2,4,6).
- States: IDLE, SCAN, RESOLVE.
- IDLE with `start`=1: latch `board`, clear the `agent_hit`/`opp_hit` flags, set the line counter to 0, go to SCAN.
- SCAN: evaluate line[counter] on the latched board.
  - All three cells == AGENT_MARK sets `agent_hit`; all three == OPP_MARK sets `opp_hit`.
  - On the first hit of either kind, record the counter into the pending `win_line`.
  - Counter 7 goes to RESOLVE; otherwise increment. No early exit: all 8 lines are always scanned.
- RESOLVE: register the outputs, pulse `valid`, return to IDLE. Priority, highest first:
  - Any cell == 11, or `agent_hit` && `opp_hit`: `err`=1, `game_state`=00, `win_line`=0.
  - `agent_hit`: 10.
  - `opp_hit`: 11.
  - No empty cell: 01 (draw).
  - Otherwise: 00.
  - `err`=0 for every non-error outcome.
- Changes to `board` after the latch edge have no effect on the running evaluation.
- `start` while busy (SCAN/RESOLVE) is ignored and not queued.
- Piece counts are not checked; only cell codes and double-winner are error conditions.
- Counter width is 3 bits; wrap from 7 to 0 happens only through the RESOLVE→IDLE path.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `game_state`=00, `valid`=0, `busy`=0, `err`=0, `win_line`=0, counter 0, flags cleared.
- Reset mid-evaluation aborts the evaluation with no `valid` pulse. Reset overrides `start` in the same cycle.
- `start` sampled at edge E0; `busy`=1 after E0.
- Lines 0..7 are evaluated in the cycles ending at edges E1..E8.
- RESOLVE occupies the cycle ending at E9. After E9, `game_state`/`err`/`win_line` are updated, `valid`=1 and `busy`=0.
- `valid` falls after E10 unless the evaluation restarts.
- Latency is 9 cycles from the `start` sample to `valid`.
- Back-to-back: `start` high in the cycle where `valid`=1 is accepted at E10; the next `valid` follows after E19. Throughput is one evaluation per 10 cycles.
- `game_state` is stable from the `valid` cycle until the next valid update or reset. `reward_gen` may consume it combinationally at any time.

## Test plan
- Reset then idle: with `rst_n`=0 for 2 cycles, all outputs are 0. With `start`=0 for 20 cycles, no `valid` pulse occurs.
- Agent row win: board cells 0,1,2=01, cells 4,5=10, rest 00, pulse `start`. Expect `valid` exactly 9 cycles later with `game_state`=10, `win_line`=0, `err`=0.
- Opponent anti-diagonal: cells 2,4,6=10, cells 0,1=01. Expect `game_state`=11, `win_line`=7. Changing `board` during SCAN must not alter the result.
- Draw and continue:
  - Full board X O X / X O O / O X X (all cells 01/10, no line): expect 01.
  - The same board with cell 8 = 00: expect 00.
- Errors:
  - Cell 3 = 11: `err`=1, `game_state`=00.
  - Row 0 all 01 and row 2 all 10: `err`=1, `game_state`=00, `win_line`=0.
- Handshake edges:
  - `start` held high continuously: one `valid` every 10 cycles.
  - `start` pulsed during SCAN: ignored.
  - `rst_n` low at scan cycle 4: no `valid`, outputs at reset values, a fresh `start` works.
